// File: rtl/axi_req_fifo_pkg.sv
// Field layout and width helper for AXI3 AR/AW request entries.
// Entry is {id, addr, len, size, burst, lock, cache, prot}, prot at the LSBs.
package axi_req_fifo_pkg;

   localparam int LEN_W   = 4;
   localparam int SIZE_W  = 2;
   localparam int BURST_W = 2;
   localparam int LOCK_W  = 2;
   localparam int CACHE_W = 4;
   localparam int PROT_W  = 3;

   localparam int PROT_LSB  = 0;
   localparam int CACHE_LSB = PROT_LSB + PROT_W;
   localparam int LOCK_LSB  = CACHE_LSB + CACHE_W;
   localparam int BURST_LSB = LOCK_LSB + LOCK_W;
   localparam int SIZE_LSB  = BURST_LSB + BURST_W;
   localparam int LEN_LSB   = SIZE_LSB + SIZE_W;
   localparam int ADDR_LSB  = LEN_LSB + LEN_W;

   function automatic int entry_width(input int tag_bits, input int addr_w);
      return tag_bits + addr_w + ADDR_LSB;
   endfunction

endpackage

// File: rtl/axi_req_fifo_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
// Storage is deliberately left unreset.
module axi_req_fifo_mem #(
   parameter int DEPTH = 4,
   parameter int W     = 50,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_req_fifo.sv
// Request FIFO for AXI3 address-channel entries with count, almost-full, flush and high-water mark.
// Optional same-cycle bypass when empty under AXI_REQ_FIFO_BYPASS_EN.
module axi_req_fifo
   import axi_req_fifo_pkg::*;
#(
   parameter int TAG_BITS     = 1,
   parameter int ADDR_W       = 32,
   parameter int DEPTH        = 4,
   parameter int AFULL_THRESH = 3,
   localparam int W           = entry_width(TAG_BITS, ADDR_W),
   localparam int CW          = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_entry,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_entry,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full,
   output logic          almost_full,
   output logic [CW-1:0] hwm
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] hwm_q, hwm_d;
   logic          push, pop, we, re, byp_pass;
   logic [W-1:0]  rdata;

   assign empty       = (count_q == '0);
   assign full        = (count_q == CW'(DEPTH));
   assign almost_full = (count_q >= CW'(AFULL_THRESH));
   assign in_ready    = !full && !flush;
   assign push        = in_valid && in_ready;
   assign count       = count_q;
   assign hwm         = hwm_q;

`ifdef AXI_REQ_FIFO_BYPASS_EN
   // Empty FIFO presents the incoming entry directly; it is only stored if not taken.
   assign out_valid = !empty || (in_valid && !flush);
   assign out_entry = empty ? in_entry : rdata;
   assign byp_pass  = empty && push && out_ready;
`else
   assign out_valid = !empty;
   assign out_entry = rdata;
   assign byp_pass  = 1'b0;
`endif

   assign pop = out_valid && out_ready;
   assign we  = push && !byp_pass;
   assign re  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(we);
      rd_ptr_d = rd_ptr_q + AW'(re);
      count_d  = count_q + CW'(we) - CW'(re);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
      hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hwm_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         hwm_q    <= hwm_d;
      end
   end

   axi_req_fifo_mem #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (wr_ptr_q),
      .wdata (in_entry),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_axi_req_fifo.sv
// Bench for axi_req_fifo: queue-based reference model, per-cycle compare, directed pins.
// Honours AXI_REQ_FIFO_BYPASS_EN to select the expected empty-path behaviour.
module tb_axi_req_fifo;
   import axi_req_fifo_pkg::*;

   localparam int DEPTH = 4;
   localparam int W     = 50;
   localparam int CW    = 3;
`ifdef AXI_REQ_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_entry = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_entry;
   logic [CW-1:0] count;
   logic          empty, full, almost_full;
   logic [CW-1:0] hwm;

   int checks = 0;
   int errors = 0;
   bit run = 1'b0;

   logic [W-1:0] mq[$];
   int           m_hwm = 0;

   always #5 clk = ~clk;

   axi_req_fifo dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_entry    (in_entry),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_entry   (out_entry),
      .count       (count),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .hwm         (hwm)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic id, input logic [31:0] a);
      logic [16:0] lo;
      lo = 17'($urandom);
      return {id, a, lo};
   endfunction

   // Expected output valid given the current model contents and inputs
   function automatic bit exp_ov();
      return (mq.size() > 0) || (BYP && mq.size() == 0 && in_valid && !flush);
   endfunction

   always @(negedge clk) begin
      if (rst && run) begin
         chk("count", 64'(count), 64'(mq.size()));
         chk("empty", 64'(empty), 64'(mq.size() == 0));
         chk("full", 64'(full), 64'(mq.size() == DEPTH));
         chk("almost_full", 64'(almost_full), 64'(mq.size() >= 3));
         chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH && !flush));
         chk("hwm", 64'(hwm), 64'(m_hwm));
         chk("out_valid", 64'(out_valid), 64'(exp_ov()));
         if (exp_ov())
            chk("out_entry", 64'(out_entry), 64'((mq.size() > 0) ? mq[0] : in_entry));
      end
   end

   // One clock: decide the transaction from pre-edge state, then apply it to the model
   task automatic cycle();
      int           sz;
      bit           dpush, dpop, fl;
      logic [W-1:0] e;
      sz    = mq.size();
      fl    = flush;
      dpush = in_valid && !flush && sz < DEPTH;
      dpop  = exp_ov() && out_ready;
      e     = in_entry;
      @(posedge clk);
      if (fl) mq.delete();
      else begin
         if (dpop && sz > 0) void'(mq.pop_front());
         if (dpush && !(sz == 0 && dpop)) mq.push_back(e);
      end
      if (mq.size() > m_hwm) m_hwm = mq.size();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      mq.delete();
      m_hwm = 0;
      #2;
      rst = 1'b1;
   endtask

   initial begin
      #12 rst = 1'b1;
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_almost_full", 64'(almost_full), 64'd0);
      chk("rst_hwm", 64'(hwm), 64'd0);
      run = 1'b1;
      @(posedge clk); #1;

      // Fill to full with consumer stalled
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_entry = mk(1'b0, 32'h1000 + 32'(4 * i));
         cycle();
         if (i == 2) chk("fill3_almost_full", 64'(almost_full), 64'd1);
      end
      chk("fill4_full", 64'(full), 64'd1);
      chk("fill4_in_ready", 64'(in_ready), 64'd0);
      chk("fill4_count", 64'(count), 64'd4);
      chk("fill4_hwm", 64'(hwm), 64'd4);
      in_entry = mk(1'b0, 32'h2000);
      cycle();
      chk("fifth_refused_count", 64'(count), 64'd4);
      in_valid = 1'b0;

      // Drain in order
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_addr", 64'(out_entry[ADDR_LSB +: 32]), 64'(32'h1000 + 32'(4 * i)));
         cycle();
      end
      chk("drain_empty", 64'(empty), 64'd1);
      chk("drain_out_valid", 64'(out_valid), 64'd0);
      chk("drain_hwm", 64'(hwm), 64'd4);
      out_ready = 1'b0;

      // Steady push+pop at count 2 across pointer wrap
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_entry = mk(1'($urandom), $urandom);
         cycle();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_entry = mk(1'($urandom), $urandom);
         cycle();
         chk("wrap_count", 64'(count), 64'd2);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // Flush with simultaneous push and pop
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_entry = mk(1'b0, 32'h3000 + 32'(4 * i));
         cycle();
      end
      flush     = 1'b1;
      out_ready = 1'b1;
      in_entry  = mk(1'b1, 32'hBAD0_0000);
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_empty", 64'(empty), 64'd1);
      chk("flush_hwm", 64'(hwm), 64'd3);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("flush_no_ghost", 64'(out_valid), 64'd0);
      end
      out_ready = 1'b0;

      // Asynchronous reset between edges
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_entry = mk(1'b0, $urandom);
         cycle();
      end
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      mq.delete();
      m_hwm = 0;
      #1;
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_hwm", 64'(hwm), 64'd0);
      rst = 1'b1;
      cycle();

      // Empty-path latency: bypass or one cycle
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_entry  = {1'b1, 32'hDEAD_0000, 17'h0};
      #1;
      chk("byp_same_cycle_valid", 64'(out_valid), 64'(BYP));
      if (BYP) chk("byp_entry", 64'(out_entry), 64'({1'b1, 32'hDEAD_0000, 17'h0}));
      cycle();
      in_valid = 1'b0;
      chk("byp_count", 64'(count), BYP ? 64'd0 : 64'd1);
      chk("byp_next_valid", 64'(out_valid), BYP ? 64'd0 : 64'd1);
      cycle();
      out_ready = 1'b0;

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 35 : 75));
         flush     = ($urandom_range(0, 99) < 3);
         in_entry  = mk(1'($urandom), $urandom);
         cycle();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) cycle();
      chk("final_empty", 64'(empty), 64'd1);

      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_req_fifo.md
Name: axi_req_fifo

Overview:
Parametrised-depth request FIFO for AXI3 AR/AW address-channel entries, sitting between a master's request generator and its channel output register.
- Both sides use valid/ready handshakes.
- Provides occupancy count, almost-full, synchronous flush and a high-water mark.
- Optional zero-latency bypass when empty.

Parameters:
TAG_BITS, 1, width of ID field
ADDR_W, 32, address field width
DEPTH, 4, number of entries; power of two, >= 2
AFULL_THRESH, 3, almost_full asserts when count >= this; legal range 1..DEPTH
(Derived: W = TAG_BITS + ADDR_W + 17; CW = clog2(DEPTH) + 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
flush  in  1  synchronous clear of contents
in_valid  in  1  producer has entry
in_ready  out  1  FIFO accepts entry
in_entry  in  W  {id, addr, len[4], size[2], burst[2], lock[2], cache[4], prot[3]}; id is the MSBs, prot the LSBs
out_valid  out  1  head entry valid
out_ready  in  1  consumer takes head
out_entry  out  W  head entry
count  out  CW  current occupancy, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AFULL_THRESH
hwm  out  CW  maximum count reached since reset

Behaviour:
- Reset (rst low, async): write/read pointers = 0, count = 0, hwm = 0.
  - Resulting outputs: empty = 1, full = 0, out_valid = 0, in_ready = 1.
  - almost_full = 0 (AFULL_THRESH >= 1).
  - Storage contents are not reset; out_entry is don't-care while out_valid = 0.
- Push: occurs on a clk edge when in_valid && in_ready.
  - in_ready = !full && !flush; combinational, with no dependence on in_valid.
- Pop: occurs when out_valid && out_ready.
  - out_valid = !empty; out_entry = mem[rd_ptr].
- Latency: an entry pushed at edge N is visible on out_entry/out_valid after edge N (1 cycle).
- Push and pop in the same cycle: count unchanged, both pointers advance.
  - Legal at any count except count == DEPTH, where the push is refused (in_ready = 0).
- Pointers: log2(DEPTH) bits, wrap naturally DEPTH-1 -> 0. Count is the single source of truth for empty/full.
- Pop when empty, or push when full: impossible by handshake; the FIFO ignores such attempts (no pointer or count change).
- Flush (sampled at clk edge):
  - Pointers and count go to 0.
  - Any simultaneous push or pop is discarded; in_ready = 0 during the flush cycle.
  - hwm is NOT cleared by flush.
- hwm: updates to the next-state count whenever next count > hwm. It is monotonic until reset.
- Mid-operation reset: all state returns to reset values immediately. Entries are lost; there is no handshake completion.

Optional Feature:
Macro AXI_REQ_FIFO_BYPASS_EN.
- Defined:
  - When count == 0 and in_valid, out_valid = 1 combinationally and out_entry = in_entry.
  - If out_ready is also high, the entry passes through: no write, count stays 0, hwm unchanged.
  - If out_ready is low, the entry is stored normally.
  - During flush, bypass is suppressed: out_valid = 0.
- Not defined: strict 1-cycle minimum latency as above; no combinational path from in_* to out_*.

Decomposition:
- Package axi_req_fifo_pkg holds:
  - field widths (LEN_W = 4, SIZE_W = 2, BURST_W = 2, LOCK_W = 2, CACHE_W = 4, PROT_W = 3);
  - field bit-offset constants relative to the LSB;
  - a function computing W from TAG_BITS/ADDR_W.
- One sub-module, axi_req_fifo_mem:
  - DEPTH x W register array, write port (we, waddr, wdata), asynchronous read port (raddr, rdata).
  - No reset on storage.
- Pointer/count/flag/hwm control lives in the top module.

Test Plan:
- Reset then fill (DEPTH = 4): push 4 entries with addr 0x1000, 0x1004, 0x1008, 0x100C, out_ready = 0.
  - After push 3: almost_full = 1.
  - After push 4: full = 1, in_ready = 0, count = 4, hwm = 4.
  - Fifth in_valid is refused.
- Drain order: from full, out_ready = 1 for 4 cycles -> out_entry addr sequence 0x1000, 0x1004, 0x1008, 0x100C; then empty = 1, out_valid = 0, hwm stays 4.
- Wrap and simultaneous: hold count = 2, then push + pop every cycle for 10 cycles -> count stays 2, FIFO order preserved across pointer wrap, no duplicate or lost entry.
- Flush with traffic: count = 3, assert flush with in_valid = 1 and out_ready = 1.
  - Next cycle: count = 0, empty = 1, hwm = 3.
  - The pushed entry never appears on the output.
- Async reset mid-burst: count = 2, drop rst asynchronously mid-cycle -> count = 0, out_valid = 0, hwm = 0 immediately, before the next clk edge.
- Bypass (macro defined): empty, in_valid = 1, out_ready = 1, in_entry id = 1, addr = 0xDEAD0000 -> same-cycle out_valid = 1 with matching out_entry; count remains 0. Without the macro: out_valid rises one cycle later.
